// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared widths, limits and scheduler state encoding for the hyperbolic CORDIC front end
package cordic_pkg;

    localparam int unsigned THETA_W   = 7;
    localparam int unsigned DATA_W    = 42;
    localparam int unsigned FRAC_W    = 34;
    localparam int unsigned THETA_MAX = 90;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESULT    = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts one past the pointer
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] pointer,
    output logic [N-1:0]  grant
);

    localparam int SW = PW + 1;

    logic [SW-1:0] sum;
    logic [PW-1:0] idx;
    logic          found;

    // Walk the requesters in order pointer+1, pointer+2, ... (mod N) and grant the first one asserted
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            sum = {1'b0, pointer} + SW'(i);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_req_scheduler.sv
// rtl/cordic_req_scheduler.sv - round-robin request scheduler for the shared Sinh/Cosh CORDIC block; optional WAIT_DONE timeout via CORDIC_SCHED_TIMEOUT_EN
module cordic_req_scheduler
    import cordic_pkg::*;
#(
    parameter  int NREQ           = 2,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int ID_W           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [THETA_W*NREQ-1:0]    req_theta,
    output logic [NREQ-1:0]            req_ready,
    output logic                       cordic_start,
    output logic [THETA_W-1:0]         cordic_theta,
    input  logic                       cordic_done,
    input  logic signed [DATA_W-1:0]   cordic_sinh,
    input  logic signed [DATA_W-1:0]   cordic_cosh,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [ID_W-1:0]            res_id,
    output logic signed [DATA_W-1:0]   res_sinh,
    output logic signed [DATA_W-1:0]   res_cosh,
    output logic                       res_err,
    output logic                       busy
);

    sched_state_t       state;
    sched_state_t       state_nxt;
    logic [ID_W-1:0]    pointer;
    logic [NREQ-1:0]    grant;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    scan_idx;
    logic [THETA_W-1:0] theta_arr [NREQ];
    logic [THETA_W-1:0] theta_sel;
    logic [THETA_W-1:0] theta_q;
    logic               accept;
    logic               range_bad;
    logic               timeout_hit;

    for (genvar k = 0; k < NREQ; k++) begin : g_theta
        assign theta_arr[k] = req_theta[k*THETA_W +: THETA_W];
    end

    rr_arbiter #(
        .N  (NREQ),
        .PW (ID_W)
    ) u_arb (
        .req     (req_valid),
        .pointer (pointer),
        .grant   (grant)
    );

    // Encode the one-hot grant into a requester index
    always_comb begin
        grant_idx = '0;
        scan_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = ID_W'(i);
            if (grant[scan_idx]) begin
                grant_idx = scan_idx;
            end
        end
    end

    assign theta_sel    = theta_arr[grant_idx];
    assign range_bad    = theta_sel > THETA_W'(THETA_MAX);
    assign accept       = (state == IDLE) && (|grant);
    assign cordic_theta = theta_q;

`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Cycles spent in WAIT_DONE; held at zero everywhere else so it restarts on each entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state != WAIT_DONE) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (state == WAIT_DONE) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a done pulse outside WAIT_DONE has no effect
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = range_bad ? RESULT : ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (cordic_done || timeout_hit) begin
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from the state; req_ready only ever mirrors the grant while IDLE
    always_comb begin
        cordic_start = (state == ISSUE);
        res_valid    = (state == RESULT);
        busy         = (state != IDLE);
        req_ready    = (state == IDLE) ? grant : '0;
    end

    // Request capture, round-robin pointer and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pointer  <= ID_W'(NREQ - 1);
            theta_q  <= '0;
            res_id   <= '0;
            res_sinh <= '0;
            res_cosh <= '0;
            res_err  <= 1'b0;
        end else begin
            if (accept) begin
                pointer  <= grant_idx;
                theta_q  <= theta_sel;
                res_id   <= grant_idx;
                res_sinh <= '0;
                res_cosh <= '0;
                res_err  <= range_bad;
            end else if (state == WAIT_DONE) begin
                if (cordic_done) begin
                    res_sinh <= cordic_sinh;
                    res_cosh <= cordic_cosh;
                    res_err  <= 1'b0;
                end else if (timeout_hit) begin
                    res_sinh <= '0;
                    res_cosh <= '0;
                    res_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cordic_req_scheduler.sv
// tb/tb_cordic_req_scheduler.sv - directed self-checking bench for cordic_req_scheduler; define CORDIC_SCHED_TIMEOUT_EN to add the timeout scenario
module tb_cordic_req_scheduler;

    localparam int NREQ = 2;
`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int TO        = 10;
    localparam int MODEL_LAT = 8;
`else
    localparam int TO        = 255;
    localparam int MODEL_LAT = 72;
`endif
    localparam logic [41:0] ONE_Q = 42'd17179869184;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [13:0] req_theta = '0;
    logic [1:0]  req_ready;
    logic        cordic_start;
    logic [6:0]  cordic_theta;
    logic        cordic_done;
    logic [41:0] cordic_sinh;
    logic [41:0] cordic_cosh;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [0:0]  res_id;
    logic [41:0] res_sinh;
    logic [41:0] res_cosh;
    logic        res_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic       model_en = 1'b1;
    logic       stray_done = 1'b0;
    logic       armed;
    int         dly;
    logic [6:0] model_theta;

    cordic_req_scheduler #(
        .NREQ           (NREQ),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_theta    (req_theta),
        .req_ready    (req_ready),
        .cordic_start (cordic_start),
        .cordic_theta (cordic_theta),
        .cordic_done  (cordic_done),
        .cordic_sinh  (cordic_sinh),
        .cordic_cosh  (cordic_cosh),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_id       (res_id),
        .res_sinh     (res_sinh),
        .res_cosh     (res_cosh),
        .res_err      (res_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [41:0] m_cosh(input logic [6:0] th);
        m_cosh = ONE_Q + 42'(th) * 42'd1000;
    endfunction

    function automatic logic [41:0] m_sinh(input logic [6:0] th);
        m_sinh = 42'(th) * 42'd777;
    endfunction

    // CORDIC model: done MODEL_LAT cycles after the start pulse
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed       <= 1'b0;
            dly         <= 0;
            model_theta <= '0;
        end else if (armed) begin
            if (dly == 0) armed <= 1'b0;
            else          dly   <= dly - 1;
        end else if (cordic_start && model_en) begin
            armed       <= 1'b1;
            dly         <= MODEL_LAT - 1;
            model_theta <= cordic_theta;
        end
    end

    assign cordic_done = (armed && dly == 0) || stray_done;
    assign cordic_cosh = stray_done ? 42'h456 : m_cosh(model_theta);
    assign cordic_sinh = stray_done ? 42'h123 : m_sinh(model_theta);

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(input int idx, output int t);
        t = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready != 2'b00) begin
                t = cyc;
                break;
            end
            step();
        end
        checks++;
        if (t < 0 || req_ready !== (2'b01 << idx)) begin
            errors++;
            $display("FAIL grant_%0d: req_ready=%b required %b", idx, req_ready, 2'b01 << idx);
        end
    endtask

    task automatic wait_result(input logic [1:0] drop, input int budget,
                               output int t, output int t_start, output int starts);
        t       = -1;
        t_start = -1;
        starts  = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (i == 0) req_valid = req_valid & ~drop;
            if (cordic_start) begin
                starts++;
                if (t_start < 0) t_start = cyc;
            end
            if (res_valid) begin
                t = cyc;
                break;
            end
        end
        checks++;
        if (t < 0) begin
            errors++;
            $display("FAIL result_wait: res_valid=%b required 1 within %0d cycles", res_valid, budget);
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL handshake: res_valid=%b busy=%b required 0 0", res_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({req_ready, cordic_start, cordic_theta, res_valid, res_id, res_sinh, res_cosh, res_err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b start=%b valid=%b busy=%b required all 0",
                     req_ready, cordic_start, res_valid, busy);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int t, tr, ts, ns;
        req_theta[6:0] = 7'd0;
        req_valid      = 2'b01;
        wait_grant(0, t);
        wait_result(2'b01, 200, tr, ts, ns);
        checks++;
        if (ts - t !== 1 || ns !== 1) begin
            errors++;
            $display("FAIL single_start: offset=%0d count=%0d required 1 1", ts - t, ns);
        end
        checks++;
        if (tr - t !== MODEL_LAT + 2) begin
            errors++;
            $display("FAIL single_latency: got %0d required %0d", tr - t, MODEL_LAT + 2);
        end
        checks++;
        if (res_id !== 1'b0 || res_cosh !== 42'd17179869184 || res_sinh !== 42'd0 || res_err !== 1'b0) begin
            errors++;
            $display("FAIL single_data: id=%0d cosh=%0d sinh=%0d err=%b required 0 17179869184 0 0",
                     res_id, res_cosh, res_sinh, res_err);
        end
        handshake();
    endtask

    task automatic test_range_error();
        int t, tr, ts, ns;
        req_theta[13:7] = 7'd91;
        req_valid       = 2'b10;
        wait_grant(1, t);
        wait_result(2'b10, 20, tr, ts, ns);
        checks++;
        if (tr - t !== 1 || ns !== 0) begin
            errors++;
            $display("FAIL range_timing: offset=%0d starts=%0d required 1 0", tr - t, ns);
        end
        checks++;
        if (res_id !== 1'b1 || res_err !== 1'b1 || res_cosh !== 42'd0 || res_sinh !== 42'd0) begin
            errors++;
            $display("FAIL range_data: id=%0d err=%b cosh=%0d sinh=%0d required 1 1 0 0",
                     res_id, res_err, res_cosh, res_sinh);
        end
        handshake();
    endtask

    task automatic test_contention();
        int t, tr, ts, ns;
        logic [6:0] th;
        req_theta = {7'd20, 7'd10};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            th = (k % 2 == 0) ? 7'd10 : 7'd20;
            wait_grant(k % 2, t);
            wait_result(2'b00, 200, tr, ts, ns);
            checks++;
            if (res_id !== 1'(k % 2) || ns !== 1 || res_err !== 1'b0) begin
                errors++;
                $display("FAIL contention_%0d: id=%0d starts=%0d err=%b required %0d 1 0",
                         k, res_id, ns, res_err, k % 2);
            end
            checks++;
            if (res_cosh !== m_cosh(th) || res_sinh !== m_sinh(th)) begin
                errors++;
                $display("FAIL contention_data_%0d: cosh=%0d sinh=%0d required %0d %0d",
                         k, res_cosh, res_sinh, m_cosh(th), m_sinh(th));
            end
            handshake();
        end
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        int t, tr, ts, ns;
        req_theta = {7'd40, 7'd30};
        req_valid = 2'b01;
        wait_grant(0, t);
        wait_result(2'b01, 200, tr, ts, ns);
        req_valid[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) stray_done = 1'b1;
            if (i == 6) stray_done = 1'b0;
            checks++;
            if ({res_valid, res_id, res_cosh, res_sinh, res_err, req_ready, cordic_start}
                !== {1'b1, 1'b0, m_cosh(7'd30), m_sinh(7'd30), 1'b0, 2'b00, 1'b0}) begin
                errors++;
                $display("FAIL hold_%0d: valid=%b id=%0d cosh=%0d sinh=%0d ready=%b required 1 0 %0d %0d 00",
                         i, res_valid, res_id, res_cosh, res_sinh, req_ready, m_cosh(7'd30), m_sinh(7'd30));
            end
            step();
        end
        stray_done = 1'b0;
        handshake();
        wait_grant(1, t);
        wait_result(2'b10, 200, tr, ts, ns);
        checks++;
        if (res_id !== 1'b1 || res_cosh !== m_cosh(7'd40) || res_sinh !== m_sinh(7'd40) || ns !== 1) begin
            errors++;
            $display("FAIL after_hold: id=%0d cosh=%0d starts=%0d required 1 %0d 1", res_id, res_cosh, ns, m_cosh(7'd40));
        end
        handshake();
    endtask

`ifdef CORDIC_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int t, tr, ts, ns;
        model_en       = 1'b0;
        req_theta[6:0] = 7'd5;
        req_valid      = 2'b01;
        wait_grant(0, t);
        wait_result(2'b01, 60, tr, ts, ns);
        checks++;
        if (tr - t !== 13 || ns !== 1) begin
            errors++;
            $display("FAIL timeout_timing: offset=%0d starts=%0d required 13 1", tr - t, ns);
        end
        checks++;
        if (res_err !== 1'b1 || res_cosh !== 42'd0 || res_sinh !== 42'd0) begin
            errors++;
            $display("FAIL timeout_data: err=%b cosh=%0d sinh=%0d required 1 0 0", res_err, res_cosh, res_sinh);
        end
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_err !== 1'b1 || res_cosh !== 42'd0) begin
            errors++;
            $display("FAIL late_done_result: valid=%b err=%b cosh=%0d required 1 1 0", res_valid, res_err, res_cosh);
        end
        handshake();
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || cordic_start !== 1'b0) begin
            errors++;
            $display("FAIL late_done_idle: busy=%b valid=%b start=%b required 0 0 0", busy, res_valid, cordic_start);
        end
        model_en       = 1'b1;
        req_theta[6:0] = 7'd0;
        req_valid      = 2'b01;
        wait_grant(0, t);
        wait_result(2'b01, 200, tr, ts, ns);
        checks++;
        if (tr - t !== MODEL_LAT + 2 || res_err !== 1'b0 || res_cosh !== ONE_Q) begin
            errors++;
            $display("FAIL after_timeout: offset=%0d err=%b cosh=%0d required %0d 0 %0d",
                     tr - t, res_err, res_cosh, MODEL_LAT + 2, ONE_Q);
        end
        handshake();
    endtask
`endif

    task automatic test_reset_mid();
        int t, tr, ts, ns;
        req_theta[13:7] = 7'd50;
        req_valid       = 2'b10;
        wait_grant(1, t);
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) req_valid = 2'b00;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, cordic_start, cordic_theta, res_valid, res_id, res_sinh, res_cosh, res_err, busy} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b start=%b theta=%0d valid=%b required all 0",
                     busy, cordic_start, cordic_theta, res_valid);
        end
        step();
        step();
        rst_n     = 1'b1;
        req_theta = {7'd0, 7'd0};
        req_valid = 2'b11;
        wait_grant(0, t);
        wait_result(2'b11, 200, tr, ts, ns);
        checks++;
        if (res_id !== 1'b0 || ns !== 1 || tr - t !== MODEL_LAT + 2 || res_cosh !== ONE_Q) begin
            errors++;
            $display("FAIL post_reset: id=%0d starts=%0d offset=%0d cosh=%0d required 0 1 %0d %0d",
                     res_id, ns, tr - t, res_cosh, MODEL_LAT + 2, ONE_Q);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_single();
        test_range_error();
        test_contention();
        test_backpressure();
`ifdef CORDIC_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
